dbg_cmd_framer: RTL and testbench

- Sequencer that turns word-level debug-bridge requests (memory write/read) into the byte-serial command frames consumed by the debug bridge UART path.
- Frame format: cmd byte, length byte, 4 address bytes, then payload bytes.
- Sits in front of the byte TX FIFO (dbg_bridge_fifo) feeding dbg_bridge_uart. It replaces hand-built byte tables with a request/handshake interface usable by on-chip or bench masters.

---
 rtl/dbg_cmd_framer.sv | 198 +++++++++++++++++++
 tb/tb_dbg_cmd_framer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_cmd_framer.sv
// Turns word-level debug-bridge read/write requests into byte-serial command frames:
// cmd, len, addr[31:24..7:0], then payload bytes taken MSB-first from 32-bit words.
module dbg_cmd_framer #(
   parameter logic [7:0] CMD_WRITE = 8'h10,
   parameter logic [7:0] CMD_READ  = 8'h11,
   parameter int         LEN_W     = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   input  logic             req_write_i,
   input  logic [31:0]      req_addr_i,
   input  logic [LEN_W-1:0] req_len_i,
   output logic             req_accept_o,
   input  logic             wr_valid_i,
   input  logic [31:0]      wr_data_i,
   output logic             wr_accept_o,
   output logic             tx_valid_o,
   output logic [7:0]       tx_data_o,
   input  logic             tx_accept_i,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [2:0] {IDLE, CMD, LEN, ADDR, DATA, DONE} state_t;

   state_t           state_reg, state_next;
   logic             write_reg, write_next;
   logic [31:0]      addr_reg, addr_next;
   logic [LEN_W-1:0] len_reg, len_next;
   logic [1:0]       acnt_reg, acnt_next;
   logic [LEN_W-1:0] bcnt_reg, bcnt_next;
   logic [31:0]      word_reg, word_next;
   logic             held_reg, held_next;
   logic             tx_valid_reg, tx_valid_next;
   logic [7:0]       tx_data_reg, tx_data_next;

   logic             load_en;
   logic             need_word;
   logic             wr_take;
   logic             byte_avail;
   logic             do_pay;
   logic             last_byte;
   logic [1:0]       lane;
   logic [1:0]       addr_sel;
   logic [31:0]      src_word;
   logic [7:0]       pay_byte;
   logic [7:0]       addr_byte;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= IDLE;
         write_reg    <= 1'b0;
         addr_reg     <= '0;
         len_reg      <= '0;
         acnt_reg     <= '0;
         bcnt_reg     <= '0;
         word_reg     <= '0;
         held_reg     <= 1'b0;
         tx_valid_reg <= 1'b0;
         tx_data_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         write_reg    <= write_next;
         addr_reg     <= addr_next;
         len_reg      <= len_next;
         acnt_reg     <= acnt_next;
         bcnt_reg     <= bcnt_next;
         word_reg     <= word_next;
         held_reg     <= held_next;
         tx_valid_reg <= tx_valid_next;
         tx_data_reg  <= tx_data_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      write_next    = write_reg;
      addr_next     = addr_reg;
      len_next      = len_reg;
      acnt_next     = acnt_reg;
      bcnt_next     = bcnt_reg;
      word_next     = word_reg;
      held_next     = held_reg;
      tx_valid_next = tx_valid_reg;
      tx_data_next  = tx_data_reg;
      do_pay        = 1'b0;

      load_en   = !tx_valid_reg || tx_accept_i;
      lane      = bcnt_reg[1:0];
      last_byte = ({1'b0, bcnt_reg} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, len_reg};
      // Word 0 is fetched while addr[7:0] sits in the output register, so the
      // first payload byte can follow the address with no idle cycle.
      need_word = !held_reg && (lane == 2'd0) && (bcnt_reg < len_reg) &&
                  ((state_reg == DATA) ||
                   ((state_reg == ADDR) && (acnt_reg == 2'd3) && write_reg));
      wr_take    = need_word && wr_valid_i;
      src_word   = held_reg ? word_reg : wr_data_i;
      byte_avail = held_reg || wr_take;

      case (lane)
         2'd0:    pay_byte = src_word[31:24];
         2'd1:    pay_byte = src_word[23:16];
         2'd2:    pay_byte = src_word[15:8];
         default: pay_byte = src_word[7:0];
      endcase

      addr_sel = acnt_reg + 2'd1;
      case (addr_sel)
         2'd0:    addr_byte = addr_reg[31:24];
         2'd1:    addr_byte = addr_reg[23:16];
         2'd2:    addr_byte = addr_reg[15:8];
         default: addr_byte = addr_reg[7:0];
      endcase

      if (wr_take) begin
         held_next = 1'b1;
         word_next = wr_data_i;
      end

      case (state_reg)
         IDLE: begin
            if (req_valid_i) begin
               write_next    = req_write_i;
               addr_next     = req_addr_i;
               len_next      = req_len_i;
               acnt_next     = '0;
               bcnt_next     = '0;
               held_next     = 1'b0;
               tx_data_next  = req_write_i ? CMD_WRITE : CMD_READ;
               tx_valid_next = 1'b1;
               state_next    = CMD;
            end
         end
         CMD: begin
            if (load_en) begin
               tx_data_next = 8'(len_reg);
               state_next   = LEN;
            end
         end
         LEN: begin
            if (load_en) begin
               tx_data_next = addr_reg[31:24];
               acnt_next    = '0;
               state_next   = ADDR;
            end
         end
         ADDR: begin
            if (load_en) begin
               if (acnt_reg != 2'd3) begin
                  acnt_next    = addr_sel;
                  tx_data_next = addr_byte;
               end else if (write_reg && (len_reg != '0)) begin
                  state_next = DATA;
                  if (byte_avail) do_pay = 1'b1;
                  else            tx_valid_next = 1'b0;
               end else begin
                  state_next    = DONE;
                  tx_valid_next = 1'b0;
               end
            end
         end
         DATA: begin
            if (load_en) begin
               if (bcnt_reg == len_reg) begin
                  state_next    = DONE;
                  tx_valid_next = 1'b0;
               end else if (byte_avail) begin
                  do_pay = 1'b1;
               end else begin
                  tx_valid_next = 1'b0;
               end
            end
         end
         DONE: begin
            tx_valid_next = 1'b0;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // The held word is released once its last useful lane has been loaded.
      if (do_pay) begin
         tx_data_next  = pay_byte;
         tx_valid_next = 1'b1;
         bcnt_next     = bcnt_reg + {{(LEN_W-1){1'b0}}, 1'b1};
         if ((lane == 2'd3) || last_byte) held_next = 1'b0;
      end
   end

   assign req_accept_o = (state_reg == IDLE);
   assign wr_accept_o  = need_word;
   assign tx_valid_o   = tx_valid_reg;
   assign tx_data_o    = tx_data_reg;
   assign busy_o       = (state_reg != IDLE) && (state_reg != DONE);
   assign done_o       = (state_reg == DONE);

endmodule

// File: tb/tb_dbg_cmd_framer.sv
// Self-checking bench for dbg_cmd_framer: directed vector table, reset-mid-frame
// sequence and randomized frames compared against a byte-list frame model.
module tb_dbg_cmd_framer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [7:0]  req_len;
   logic        req_accept;
   logic        wr_valid;
   logic [31:0] wr_data;
   logic        wr_accept;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_accept;
   logic        busy;
   logic        done;

   dbg_cmd_framer dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_write_i (req_write),
      .req_addr_i  (req_addr),
      .req_len_i   (req_len),
      .req_accept_o(req_accept),
      .wr_valid_i  (wr_valid),
      .wr_data_i   (wr_data),
      .wr_accept_o (wr_accept),
      .tx_valid_o  (tx_valid),
      .tx_data_o   (tx_data),
      .tx_accept_i (tx_accept),
      .busy_o      (busy),
      .done_o      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit              w;
      logic [31:0]     addr;
      logic [7:0]      len;
      logic [3:0][31:0] words;   // words[0] is the first payload word
      int              mode;     // 0: tx_accept held high, 1: random
      int              gap_at;   // word index preceded by a wr_valid gap, -1 none
      int              gap_len;
      int              exp_bytes;
      int              exp_words;
      int              exp_bubble; // 0: none, 1: at least one, 2: don't care
   } vec_t;

   int errors = 0;
   int checks = 0;

   logic [7:0]  got[$];
   logic [7:0]  exp_q[$];
   logic [31:0] wsrc[$];
   logic [31:0] wq[$];

   int   cyc = 0;
   int   acc_mode = 0;
   int   gap_at = -1;
   int   gap_len = 0;
   int   gap_cnt = 0;
   int   words_taken = 0;
   int   done_cnt = 0;
   int   bubble_cnt = 0;
   int   first_cyc = -1;
   int   last_cyc = 0;
   int   done_cyc = 0;
   logic done_tv, done_busy, done_racc;
   bit   req_taken = 0;
   bit   wr_taken = 0;
   bit   prev_hold = 0;
   logic [7:0] prev_data = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference frame: header bytes then payload byte k from word k/4, lane k%4 MSB-first.
   function automatic void build_exp(input bit w, input logic [31:0] a, input logic [7:0] l);
      exp_q.delete();
      exp_q.push_back(w ? 8'h10 : 8'h11);
      exp_q.push_back(l);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(a >> (24 - 8 * i)));
      if (w) begin
         for (int k = 0; k < int'(l); k++)
            exp_q.push_back(8'(wsrc[k / 4] >> (24 - 8 * (k % 4))));
      end
   endfunction

   task automatic drive();
      if (req_taken) req_valid = 1'b0;
      if (wr_taken) begin
         if (wq.size() > 0) void'(wq.pop_front());
         words_taken++;
         if (words_taken == gap_at) gap_cnt = gap_len;
      end else if (gap_cnt > 0) begin
         gap_cnt--;
      end
      wr_valid  = (wq.size() > 0) && (gap_cnt == 0);
      wr_data   = (wq.size() > 0) ? wq[0] : 32'h0;
      tx_accept = (acc_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      req_taken = 0;
      wr_taken  = 0;
   endtask

   task automatic sample();
      cyc++;
      req_taken = req_valid && req_accept;
      wr_taken  = wr_valid && wr_accept;
      if (prev_hold) begin
         check("hold_valid", tx_valid, 1'b1);
         check("hold_data", tx_data, prev_data);
      end
      prev_hold = tx_valid && !tx_accept;
      prev_data = tx_data;
      if (busy) check("req_accept_busy", req_accept, 1'b0);
      if (tx_valid && tx_accept) begin
         got.push_back(tx_data);
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
      end
      if (busy && !tx_valid && got.size() > 0) bubble_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc  = cyc;
         done_tv   = tx_valid;
         done_busy = busy;
         done_racc = req_accept;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      sample();
   endtask

   task automatic begin_frame(input bit w, input logic [31:0] a, input logic [7:0] l,
                              input int mode, input int gat, input int glen);
      build_exp(w, a, l);
      wq.delete();
      foreach (wsrc[i]) wq.push_back(wsrc[i]);
      wq.push_back(32'hBAD0BAD0);   // one spare word: must never be taken
      got.delete();
      done_cnt    = 0;
      bubble_cnt  = 0;
      words_taken = 0;
      first_cyc   = -1;
      acc_mode    = mode;
      gap_at      = gat;
      gap_len     = glen;
      gap_cnt     = (gat == 0) ? glen : 0;
      req_write   = w;
      req_addr    = a;
      req_len     = l;
      req_valid   = 1'b1;
   endtask

   task automatic run_frame(input string tag, input bit w, input logic [31:0] a,
                            input logic [7:0] l, input int mode, input int gat,
                            input int glen, input int exp_bytes, input int exp_words,
                            input int exp_bubble);
      int n;
      begin_frame(w, a, l, mode, gat, glen);
      n = 0;
      while (done_cnt == 0 && n < 4000) begin
         step();
         n++;
      end
      check({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
      check({tag, "_nbytes"}, 32'(got.size()), 32'(exp_bytes));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
         if (got[i] !== exp_q[i]) break;
      end
      check({tag, "_words"}, 32'(words_taken), 32'(exp_words));
      check({tag, "_done_lat"}, 32'(done_cyc - last_cyc), 32'd1);
      check({tag, "_done_txv"}, done_tv, 1'b0);
      check({tag, "_done_busy"}, done_busy, 1'b0);
      check({tag, "_done_racc"}, done_racc, 1'b0);
      step();
      check({tag, "_racc_after"}, req_accept, 1'b1);
      check({tag, "_done_pulse"}, done, 1'b0);
      if (exp_bubble == 0) begin
         check({tag, "_b2b"}, 32'(last_cyc - first_cyc), 32'(exp_bytes - 1));
         check({tag, "_nobubble"}, 32'(bubble_cnt), 32'd0);
      end else if (exp_bubble == 1) begin
         check({tag, "_bubble"}, 32'(bubble_cnt > 0), 32'd1);
      end
      $display("frame %s: write=%0d addr=%08h len=%0d bytes=%0d words=%0d",
               tag, w, a, l, got.size(), words_taken);
      wq.delete();
      gap_at = -1;
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{1'b1, 32'h00000000, 8'd13,
                  {32'hDD000000, 32'h99AABBCC, 32'h55667788, 32'h11223344},
                  0, -1, 0, 19, 4, 0};
      vecs[1] = '{1'b0, 32'hF0000004, 8'd4, {4{32'h0}}, 0, -1, 0, 6, 0, 0};
      vecs[2] = '{1'b1, 32'h00000000, 8'd13,
                  {32'hDD000000, 32'h99AABBCC, 32'h55667788, 32'h11223344},
                  1, -1, 0, 19, 4, 2};
      vecs[3] = '{1'b1, 32'hA5A50001, 8'd8,
                  {32'h0, 32'h0, 32'h0BADF00D, 32'hCAFEBABE},
                  0, 1, 10, 14, 2, 1};
      vecs[4] = '{1'b1, 32'h12345678, 8'd0, {4{32'h0}}, 0, -1, 0, 6, 0, 0};
      vecs[5] = '{1'b1, 32'h00008001, 8'd5,
                  {32'h0, 32'h0, 32'hE5F60000, 32'hA1B2C3D4},
                  0, -1, 0, 11, 2, 0};

      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'h0;
      req_len   = 8'h0;
      wr_valid  = 1'b0;
      wr_data   = 32'h0;
      tx_accept = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_wr_accept", wr_accept, 1'b0);
      check("rst_req_accept", req_accept, 1'b1);

      for (int v = 0; v < 6; v++) begin
         wsrc.delete();
         if (vecs[v].w)
            for (int i = 0; i < (int'(vecs[v].len) + 3) / 4; i++) wsrc.push_back(vecs[v].words[i]);
         run_frame($sformatf("vec%0d", v), vecs[v].w, vecs[v].addr, vecs[v].len,
                   vecs[v].mode, vecs[v].gap_at, vecs[v].gap_len,
                   vecs[v].exp_bytes, vecs[v].exp_words, vecs[v].exp_bubble);
      end

      // Reset after the third address byte is accepted abandons the frame.
      begin
         int n;
         wsrc.delete();
         wsrc.push_back(32'h01020304);
         begin_frame(1'b1, 32'hDEADBEEF, 8'd4, 0, -1, 0);
         n = 0;
         while (got.size() < 5 && n < 100) begin
            step();
            n++;
         end
         check("midrst_reach", 32'(got.size()), 32'd5);
         @(posedge clk);
         #1 rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
         req_taken = 0;
         wr_taken  = 0;
         prev_hold = 0;
         req_valid = 1'b0;
         wq.delete();
         wr_valid  = 1'b0;
         @(negedge clk);
         check("midrst_tx_valid", tx_valid, 1'b0);
         check("midrst_busy", busy, 1'b0);
         check("midrst_req_accept", req_accept, 1'b1);
         check("midrst_done", done, 1'b0);
         $display("reset mid-frame after %0d bytes", got.size());
         wsrc.delete();
         run_frame("post_rst_read", 1'b0, 32'h00C0FFEE, 8'd9, 0, -1, 0, 6, 0, 0);
      end

      for (int r = 0; r < 20; r++) begin
         bit          w;
         logic [31:0] a;
         logic [7:0]  l;
         int          nw, mode, gat, glen;
         w    = 1'($urandom_range(0, 1));
         a    = $urandom;
         l    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
         if (r == 0) begin
            w = 1'b1;
            l = 8'd255;
         end
         nw   = w ? (int'(l) + 3) / 4 : 0;
         mode = $urandom_range(0, 1);
         gat  = (nw > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, nw - 1)) : -1;
         glen = $urandom_range(0, 6);
         wsrc.delete();
         for (int i = 0; i < nw; i++) wsrc.push_back($urandom);
         run_frame($sformatf("rnd%0d", r), w, a, l, mode, gat, glen,
                   w ? 6 + int'(l) : 6, nw, 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
